// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dm_pkg;

  localparam int unsigned WAIT_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic WEB_WRITE  = 1'b0;
  localparam logic CEB_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dm_state_e;

  // Bit-granular merge: a 0 in bweb selects the new data bit.
  function automatic logic [DATA_W-1:0] bit_merge(input logic [DATA_W-1:0] old_val,
                                                  input logic [DATA_W-1:0] new_val,
                                                  input logic [DATA_W-1:0] bweb);
    return (old_val & bweb) | (new_val & ~bweb);
  endfunction

endpackage

// File: rtl/dm_array.sv
// Data-memory storage: synchronous read, bit-masked synchronous write, no reset.
module dm_array #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [31:0]       bweb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       di,
  output logic [31:0]       dout
);
  import dm_pkg::*;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];

  // Read returns the pre-write contents when read and write share an edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= bit_merge(mem_q[addr], di, bweb);
    end
    dout <= mem_q[addr];
  end

endmodule

// File: rtl/dm_responder.sv
// Memory side of the DM_* pipeline interface: accepts requests, commits masked
// writes immediately and returns read data after WAIT wait states.
module dm_responder #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_CEB,
  input  logic              DM_WEB,
  input  logic [31:0]       DM_BWEB,
  input  logic [ADDR_W-1:0] DM_A,
  input  logic [31:0]       DM_DI,
  output logic [31:0]       DM_DO,
  output logic              DM_RVALID,
  output logic              DM_BUSY
);
  import dm_pkg::*;

  dm_state_e         state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              busy_q;
  logic              rvalid_q;
  logic [31:0]       hold_q;

  logic              accept_c;
  logic              is_wr_c;
  logic              arr_we_c;
  logic [ADDR_W-1:0] arr_addr_c;
  logic [31:0]       arr_rdata;

  assign accept_c   = (DM_CEB == CEB_ACTIVE) && !busy_q;
  assign is_wr_c    = (DM_WEB == WEB_WRITE);
  assign arr_we_c   = accept_c && is_wr_c;
  // While waiting, the array keeps reading the latched address so the sample
  // is taken at completion and sees every earlier write.
  assign arr_addr_c = (state_q == dm_pkg::WAIT) ? addr_q : DM_A;

  dm_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we_c),
    .bweb (DM_BWEB),
    .addr (arr_addr_c),
    .di   (DM_DI),
    .dout (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (rvalid_q) begin
        hold_q <= arr_rdata;
      end
      unique case (state_q)
        IDLE, RESP: begin
          state_q <= IDLE;
          if (accept_c) begin
            if (WAIT == 0) begin
              rvalid_q <= !is_wr_c;
            end else begin
              state_q <= dm_pkg::WAIT;
              busy_q  <= 1'b1;
              cnt_q   <= WAIT_W'(WAIT - 1);
              addr_q  <= DM_A;
              rd_q    <= !is_wr_c;
            end
          end
        end
        dm_pkg::WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= rd_q ? RESP : IDLE;
            rvalid_q <= rd_q;
            busy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data lives in the array's output register for the RVALID cycle and
  // is then held locally until the next read completes.
  assign DM_DO     = rvalid_q ? arr_rdata : hold_q;
  assign DM_RVALID = rvalid_q;
  assign DM_BUSY   = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (WAIT = 0, 3, 5) against a memory
// model and a transaction-level latency expectation.
module tb_dm_responder;

  localparam int unsigned AW = 6;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [NI];
  logic          ceb   [NI];
  logic          web   [NI];
  logic [31:0]   bweb  [NI];
  logic [AW-1:0] a     [NI];
  logic [31:0]   di    [NI];
  logic [31:0]   dout  [NI];
  logic          rv    [NI];
  logic          busy  [NI];

  dm_responder #(.ADDR_W(AW), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst[0]), .DM_CEB(ceb[0]), .DM_WEB(web[0]), .DM_BWEB(bweb[0]),
    .DM_A(a[0]), .DM_DI(di[0]), .DM_DO(dout[0]), .DM_RVALID(rv[0]), .DM_BUSY(busy[0]));
  dm_responder #(.ADDR_W(AW), .WAIT(3)) u_w3 (
    .clk(clk), .rst(rst[1]), .DM_CEB(ceb[1]), .DM_WEB(web[1]), .DM_BWEB(bweb[1]),
    .DM_A(a[1]), .DM_DI(di[1]), .DM_DO(dout[1]), .DM_RVALID(rv[1]), .DM_BUSY(busy[1]));
  dm_responder #(.ADDR_W(AW), .WAIT(5)) u_w5 (
    .clk(clk), .rst(rst[2]), .DM_CEB(ceb[2]), .DM_WEB(web[2]), .DM_BWEB(bweb[2]),
    .DM_A(a[2]), .DM_DI(di[2]), .DM_DO(dout[2]), .DM_RVALID(rv[2]), .DM_BUSY(busy[2]));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ref_mem [NI][64];
  logic [31:0] exp_do  [NI];

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in(input int i);
    ceb[i]  = 1'b1;
    web[i]  = 1'($urandom);
    a[i]    = AW'($urandom);
    di[i]   = $urandom;
    bweb[i] = $urandom;
  endtask

  // One full transaction; checks BUSY, RVALID and DO every cycle up to completion.
  task automatic access(input int i, input logic wr, input logic [AW-1:0] addr,
                        input logic [31:0] d, input logic [31:0] m);
    int w;
    int guard;
    w = wait_of(i);
    guard = 0;
    ceb[i] = 1'b0; web[i] = !wr; a[i] = addr; di[i] = d; bweb[i] = m;
    while (busy[i] && guard < 50) begin
      step();
      guard++;
    end
    if (busy[i]) check($sformatf("u%0d_accept_timeout", i), 32'(busy[i]), 32'd0);
    @(posedge clk);
    if (wr) ref_mem[i][addr] = (ref_mem[i][addr] & m) | (d & ~m);
    @(negedge clk);
    idle_in(i);
    for (int c = 0; c <= w; c++) begin
      if (c < w) begin
        check($sformatf("u%0d_busy_c%0d", i, c), 32'(busy[i]), 32'd1);
        check($sformatf("u%0d_rv_early_c%0d", i, c), 32'(rv[i]), 32'd0);
        step();
      end else begin
        check($sformatf("u%0d_busy_done", i), 32'(busy[i]), 32'd0);
        if (!wr) exp_do[i] = ref_mem[i][addr];
        check($sformatf("u%0d_rv_done", i), 32'(rv[i]), wr ? 32'd0 : 32'd1);
        check($sformatf("u%0d_do_a%0d", i, addr), dout[i], exp_do[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0;
      idle_in(i);
      exp_do[i] = 32'h0;
    end
    step();
    step();
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    step();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d_rst_do", i), dout[i], 32'h0);
      check($sformatf("u%0d_rst_rv", i), 32'(rv[i]), 32'd0);
      check($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 32'd0);
    end

    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 16; k++) access(i, 1'b1, AW'(k), $urandom, 32'h0);

    // Write then read, WAIT=0
    access(0, 1'b1, AW'(5), 32'hDEADBEEF, 32'h0);
    access(0, 1'b0, AW'(5), 32'h0, 32'h0);
    check("t1_do", dout[0], 32'hDEADBEEF);

    // Masked write
    access(0, 1'b1, AW'(3), 32'h11223344, 32'h0);
    access(0, 1'b1, AW'(3), 32'hAABBCCDD, 32'hFFFF00FF);
    access(0, 1'b0, AW'(3), 32'h0, 32'h0);
    check("t2_masked_do", dout[0], 32'h1122CC44);

    // WAIT=3 read, then a write held while BUSY
    access(1, 1'b0, AW'(7), 32'h0, 32'h0);
    ceb[1] = 1'b0; web[1] = 1'b1; a[1] = AW'(1);
    step();
    web[1] = 1'b0; a[1] = AW'(2); di[1] = 32'hCAFE0002; bweb[1] = 32'h0;
    check("t3_busy_k0", 32'(busy[1]), 32'd1);
    step();
    check("t3_busy_k1", 32'(busy[1]), 32'd1);
    step();
    check("t3_busy_k2", 32'(busy[1]), 32'd1);
    step();
    exp_do[1] = ref_mem[1][1];
    check("t3_busy_k3", 32'(busy[1]), 32'd0);
    check("t3_rv_k3", 32'(rv[1]), 32'd1);
    check("t3_do_k3", dout[1], exp_do[1]);
    step();
    ref_mem[1][2] = 32'hCAFE0002;
    check("t3_held_busy_k4", 32'(busy[1]), 32'd1);
    check("t3_held_rv_k4", 32'(rv[1]), 32'd0);
    idle_in(1);
    step();
    check("t3_held_busy_k5", 32'(busy[1]), 32'd1);
    step();
    check("t3_held_busy_k6", 32'(busy[1]), 32'd1);
    step();
    check("t3_held_busy_k7", 32'(busy[1]), 32'd0);
    check("t3_held_rv_k7", 32'(rv[1]), 32'd0);
    check("t3_held_do_k7", dout[1], exp_do[1]);
    access(1, 1'b0, AW'(2), 32'h0, 32'h0);
    check("t3_held_data", dout[1], 32'hCAFE0002);

    // Reset mid-WAIT on WAIT=5
    access(2, 1'b1, AW'(4), 32'h5A5A1234, 32'h0);
    access(2, 1'b0, AW'(4), 32'h0, 32'h0);
    ceb[2] = 1'b0; web[2] = 1'b1; a[2] = AW'(9);
    step();
    idle_in(2);
    step();
    step();
    rst[2] = 1'b0;
    #1;
    exp_do[2] = 32'h0;
    check("t4_rst_do", dout[2], 32'h0);
    check("t4_rst_busy", 32'(busy[2]), 32'd0);
    check("t4_rst_rv", 32'(rv[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("t4_no_rv_c%0d", c), 32'(rv[2]), 32'd0);
      check($sformatf("t4_do_c%0d", c), dout[2], 32'h0);
    end
    access(2, 1'b0, AW'(4), 32'h0, 32'h0);
    check("t4_array_kept", dout[2], 32'h5A5A1234);

    // Back-to-back WAIT=0: W7=1, R7, W7=2, R7
    ceb[0] = 1'b0; web[0] = 1'b0; a[0] = AW'(7); di[0] = 32'h1; bweb[0] = 32'h0;
    step();
    web[0] = 1'b1;
    step();
    check("t5_rv0", 32'(rv[0]), 32'd1);
    check("t5_do0", dout[0], 32'h1);
    web[0] = 1'b0; di[0] = 32'h2;
    step();
    check("t5_rv1", 32'(rv[0]), 32'd0);
    check("t5_do1", dout[0], 32'h1);
    web[0] = 1'b1;
    step();
    check("t5_rv2", 32'(rv[0]), 32'd1);
    check("t5_do2", dout[0], 32'h2);
    idle_in(0);
    step();
    check("t5_rv3", 32'(rv[0]), 32'd0);
    check("t5_do3", dout[0], 32'h2);
    ref_mem[0][7] = 32'h2;
    exp_do[0] = 32'h2;

    // Idle traffic, then an all-ones-mask write
    for (int c = 0; c < 20; c++) begin
      idle_in(0);
      step();
      check($sformatf("t6_idle_rv_c%0d", c), 32'(rv[0]), 32'd0);
      check($sformatf("t6_idle_do_c%0d", c), dout[0], 32'h2);
    end
    access(0, 1'b1, AW'(5), $urandom, 32'hFFFFFFFF);
    access(0, 1'b0, AW'(5), 32'h0, 32'h0);
    check("t6_noop_write", dout[0], 32'hDEADBEEF);

    // Randomized traffic on all instances
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 40; n++) begin
        logic        wr;
        logic [31:0] m;
        wr = 1'($urandom_range(0, 1));
        m  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        access(i, wr, AW'($urandom_range(0, 15)), $urandom, m);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
